// File: rtl/seq_reorder_pkg.sv
// Shared types, default parameters and helpers for the sequence reorder buffer.
package seq_reorder_pkg;

    localparam int unsigned DEF_MSG_W       = 168;
    localparam int unsigned DEF_SEQ_LSB     = 8;
    localparam int unsigned DEF_SEQ_W       = 32;
    localparam int unsigned DEF_DEPTH       = 64;
    localparam int unsigned DEF_GAP_TIMEOUT = 1024;

    // Upper bounds for the generic seq extraction helper.
    localparam int unsigned MAX_MSG_W = 1024;
    localparam int unsigned MAX_SEQ_W = 64;

    typedef enum logic [1:0] {
        DropNone,
        DropStale,
        DropWindow,
        DropDup
    } drop_cause_e;

    function automatic logic [MAX_SEQ_W-1:0] extract_seq(
        input logic [MAX_MSG_W-1:0] msg,
        input int unsigned          lsb,
        input int unsigned          width
    );
        logic [MAX_SEQ_W-1:0] mask;
        mask = (MAX_SEQ_W'(1) << width) - MAX_SEQ_W'(1);
        return MAX_SEQ_W'(msg >> lsb) & mask;
    endfunction

endpackage

// File: rtl/seq_reorder_buffer_slot_mem.sv
// Slot storage for the reorder buffer: one write port (which also sets the
// slot's valid bit), one asynchronous read port and a valid-bit clear port.
module seq_reorder_slot_mem
    import seq_reorder_pkg::*;
#(
    parameter int unsigned MSG_W = DEF_MSG_W,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [MSG_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [MSG_W-1:0] rd_data,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    output logic [DEPTH-1:0] valid
);

    logic [MSG_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // Data needs no reset: a slot's contents are only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[wr_idx] <= 1'b1;
            end
            if (clr_en) begin
                valid_q[clr_idx] <= 1'b0;
            end
        end
    end

    assign rd_data = mem_q[rd_idx];
    assign valid   = valid_q;

endmodule

// File: rtl/seq_reorder_buffer.sv
// Reorder buffer releasing tagged messages in ascending sequence order.
// Optional idle-gap skip timer enabled by defining SEQ_REORDER_GAP_SKIP_EN.
module seq_reorder_buffer
    import seq_reorder_pkg::*;
#(
    parameter int unsigned MSG_W       = DEF_MSG_W,
    parameter int unsigned SEQ_LSB     = DEF_SEQ_LSB,
    parameter int unsigned SEQ_W       = DEF_SEQ_W,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned GAP_TIMEOUT = DEF_GAP_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [MSG_W-1:0]             in_msg,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [MSG_W-1:0]             out_msg,
    input  logic                         out_ready,
    output logic [SEQ_W-1:0]             expected_seq,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         drop_stale,
    output logic                         drop_window,
    output logic                         drop_dup,
    output logic                         gap_skip
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    logic [SEQ_W-1:0] expected_seq_q;
    logic [OCC_W-1:0] occupancy_q, occupancy_d;
    logic             out_valid_q;
    logic [MSG_W-1:0] out_msg_q;
    logic             drop_stale_q, drop_window_q, drop_dup_q, gap_skip_q;

    logic [SEQ_W-1:0] in_seq, delta;
    logic [IDX_W-1:0] in_idx, exp_idx;
    logic [DEPTH-1:0] slot_valid;
    logic [MSG_W-1:0] rd_data;
    drop_cause_e      cause;
    logic             store, rel_en, skip_now, advance;

    assign in_seq  = SEQ_W'(extract_seq(MAX_MSG_W'(in_msg), SEQ_LSB, SEQ_W));
    assign delta   = in_seq - expected_seq_q;
    assign in_idx  = in_seq[IDX_W-1:0];
    assign exp_idx = expected_seq_q[IDX_W-1:0];

    // Classification uses the pre-edge valid bits, so a delta-0 arrival at a
    // slot being released this cycle is a duplicate, never a collision.
    always_comb begin
        cause = DropNone;
        if (in_valid) begin
            if (delta[SEQ_W-1]) begin
                cause = DropStale;
            end else if (delta >= SEQ_W'(DEPTH)) begin
                cause = DropWindow;
            end else if (slot_valid[in_idx]) begin
                cause = DropDup;
            end
        end
    end

    assign store   = in_valid && (cause == DropNone);
    assign rel_en  = slot_valid[exp_idx] && (!out_valid_q || out_ready);
    assign advance = rel_en || skip_now;

    always_comb begin
        occupancy_d = occupancy_q;
        if (store && !rel_en) begin
            occupancy_d = occupancy_q + OCC_W'(1);
        end else if (!store && rel_en) begin
            occupancy_d = occupancy_q - OCC_W'(1);
        end
    end

    seq_reorder_slot_mem #(
        .MSG_W (MSG_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_slot_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (store),
        .wr_idx  (in_idx),
        .wr_data (in_msg),
        .rd_idx  (exp_idx),
        .rd_data (rd_data),
        .clr_en  (rel_en),
        .clr_idx (exp_idx),
        .valid   (slot_valid)
    );

`ifdef SEQ_REORDER_GAP_SKIP_EN
    localparam int unsigned TMR_W = $clog2(GAP_TIMEOUT+1);

    logic [TMR_W-1:0] gap_timer_q;
    logic             gap_wait;

    // A store landing in the expected slot this edge means the gap is closing;
    // skipping now would orphan that entry behind expected_seq.
    assign gap_wait = (occupancy_q != '0) && !slot_valid[exp_idx]
                      && !(store && (in_idx == exp_idx));
    assign skip_now = gap_wait && (gap_timer_q == TMR_W'(GAP_TIMEOUT-1));

    always_ff @(posedge clk) begin
        if (rst || rel_en || skip_now || (occupancy_q == '0)) begin
            gap_timer_q <= '0;
        end else if (gap_wait) begin
            gap_timer_q <= gap_timer_q + TMR_W'(1);
        end
    end
`else
    logic unused_gap_cfg;
    assign unused_gap_cfg = (GAP_TIMEOUT == 0);
    assign skip_now       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            expected_seq_q <= '0;
            occupancy_q    <= '0;
            out_valid_q    <= 1'b0;
            out_msg_q      <= '0;
            drop_stale_q   <= 1'b0;
            drop_window_q  <= 1'b0;
            drop_dup_q     <= 1'b0;
            gap_skip_q     <= 1'b0;
        end else begin
            expected_seq_q <= expected_seq_q + SEQ_W'(advance);
            occupancy_q    <= occupancy_d;
            if (rel_en) begin
                out_valid_q <= 1'b1;
                out_msg_q   <= rd_data;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            drop_stale_q  <= (cause == DropStale);
            drop_window_q <= (cause == DropWindow);
            drop_dup_q    <= (cause == DropDup);
            gap_skip_q    <= skip_now;
        end
    end

    assign in_ready     = !rst;
    assign out_valid    = out_valid_q;
    assign out_msg      = out_msg_q;
    assign expected_seq = expected_seq_q;
    assign occupancy    = occupancy_q;
    assign drop_stale   = drop_stale_q;
    assign drop_window  = drop_window_q;
    assign drop_dup     = drop_dup_q;
    assign gap_skip     = gap_skip_q;

endmodule

// File: tb/tb_seq_reorder_buffer.sv
// Self-checking bench for seq_reorder_buffer: directed scenarios plus random
// traffic against a seq-keyed behavioural model (honours SEQ_REORDER_GAP_SKIP_EN).
module tb_seq_reorder_buffer;

    localparam int unsigned MSG_W       = 168;
    localparam int unsigned SEQ_LSB     = 8;
    localparam int unsigned SEQ_W       = 8;
    localparam int unsigned DEPTH       = 64;
    localparam int unsigned GAP_TIMEOUT = 16;
    localparam int unsigned SEQ_MOD     = 1 << SEQ_W;
    localparam int unsigned OCC_W       = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [MSG_W-1:0] in_msg = '0;
    logic             in_ready;
    logic             out_valid;
    logic [MSG_W-1:0] out_msg;
    logic             out_ready = 1'b0;
    logic [SEQ_W-1:0] expected_seq;
    logic [OCC_W-1:0] occupancy;
    logic             drop_stale, drop_window, drop_dup, gap_skip;

    int checks = 0;
    int errors = 0;

    // Model: buffer keyed by absolute sequence number, not by slot.
    logic [MSG_W-1:0] m_buf [int unsigned];
    int unsigned      m_exp;
    int unsigned      m_gap_cnt;
    bit               m_out_valid;
    logic [MSG_W-1:0] m_out_msg;
    bit               m_stale, m_window, m_dup, m_skip;

    logic [MSG_W-1:0] got_q [$];

    seq_reorder_buffer #(
        .MSG_W       (MSG_W),
        .SEQ_LSB     (SEQ_LSB),
        .SEQ_W       (SEQ_W),
        .DEPTH       (DEPTH),
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_msg       (in_msg),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_msg      (out_msg),
        .out_ready    (out_ready),
        .expected_seq (expected_seq),
        .occupancy    (occupancy),
        .drop_stale   (drop_stale),
        .drop_window  (drop_window),
        .drop_dup     (drop_dup),
        .gap_skip     (gap_skip)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [MSG_W-1:0] make_msg(input int unsigned seq);
        logic [191:0] raw;
        logic [MSG_W-1:0] m;
        for (int i = 0; i < 6; i++) raw[i*32 +: 32] = $urandom();
        m = raw[MSG_W-1:0];
        m[SEQ_LSB +: SEQ_W] = SEQ_W'(seq);
        return m;
    endfunction

    function automatic int unsigned seq_of(input logic [MSG_W-1:0] m);
        return int'(m[SEQ_LSB +: SEQ_W]);
    endfunction

    function automatic void model_reset();
        m_buf.delete();
        m_exp = 0; m_gap_cnt = 0;
        m_out_valid = 0; m_out_msg = '0;
        m_stale = 0; m_window = 0; m_dup = 0; m_skip = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [MSG_W-1:0] msg, input bit rdy);
        int unsigned s, d;
        bit do_store, rel, waiting;
        s = 0; do_store = 0;
        m_stale = 0; m_window = 0; m_dup = 0; m_skip = 0;
        if (v) begin
            s = seq_of(msg);
            d = (s + SEQ_MOD - m_exp) % SEQ_MOD;
            if (d >= SEQ_MOD / 2) m_stale = 1;
            else if (d >= DEPTH) m_window = 1;
            else if (m_buf.exists(s)) m_dup = 1;
            else do_store = 1;
        end
        rel = m_buf.exists(m_exp) && (!m_out_valid || rdy);
`ifdef SEQ_REORDER_GAP_SKIP_EN
        waiting = (m_buf.num() > 0) && !m_buf.exists(m_exp) && !(do_store && s == m_exp);
        m_skip = waiting && (m_gap_cnt == GAP_TIMEOUT - 1);
        if (rel || m_skip || m_buf.num() == 0) m_gap_cnt = 0;
        else if (waiting) m_gap_cnt++;
`else
        waiting = 0;
`endif
        if (rel) begin
            m_out_msg = m_buf[m_exp];
            m_out_valid = 1;
            m_buf.delete(m_exp);
            m_exp = (m_exp + 1) % SEQ_MOD;
        end else if (m_out_valid && rdy) begin
            m_out_valid = 0;
        end
        if (m_skip) m_exp = (m_exp + 1) % SEQ_MOD;
        if (do_store) m_buf[s] = msg;
    endfunction

    // One clock: drive inputs, record handshakes, advance model, settle.
    task automatic tick(input bit v, input logic [MSG_W-1:0] msg, input bit rdy);
        in_valid = v; in_msg = msg; out_ready = rdy;
        if (out_valid && rdy) got_q.push_back(out_msg);
        @(posedge clk);
        if (rst) model_reset();
        else model_step(v, msg, rdy);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(0, '0, 0);
        tick(0, '0, 0);
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tick(1, make_msg(0), 0);
        tick(1, make_msg(1), 0);
        tick(1, make_msg(3), 0);
        rst = 1'b1;
        tick(0, '0, 0);
        checks++;
        if ({in_ready, out_valid, occupancy, expected_seq, drop_stale, drop_window, drop_dup,
             gap_skip} !== '0 || out_msg !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b ov=%b occ=%0d exp=%0d drops=%b%b%b skip=%b msg=%h, want all 0",
                     in_ready, out_valid, occupancy, expected_seq, drop_stale, drop_window,
                     drop_dup, gap_skip, out_msg);
        end
        rst = 1'b0;
        tick(0, '0, 0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tick(1, make_msg(1), 1);
        checks++;
        if (drop_dup !== 1'b0 || occupancy !== OCC_W'(1)) begin
            errors++;
            $display("FAIL reset_discard: dup=%b occ=%0d want dup=0 occ=1", drop_dup, occupancy);
        end
        tick(0, '0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_no_out: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_in_order();
        logic [MSG_W-1:0] sent [8];
        int first;
        do_reset();
        first = -1;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                sent[c] = make_msg(c);
                tick(1, sent[c], 1);
            end else begin
                tick(0, '0, 1);
            end
            if (out_valid && first < 0) first = c;
        end
        checks++;
        if (first != 1) begin
            errors++; $display("FAIL in_order_latency: first out_valid at cycle %0d want 1", first);
        end
        checks++;
        if (got_q.size() != 8) begin
            errors++; $display("FAIL in_order_count: got %0d outputs want 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i] !== sent[i]) begin
                    errors++;
                    $display("FAIL in_order_msg[%0d]: got seq %0d want seq %0d", i,
                             seq_of(got_q[i]), i);
                end
            end
        end
        checks++;
        if (expected_seq !== SEQ_W'(8)) begin
            errors++; $display("FAIL in_order_exp: got %0d want 8", expected_seq);
        end
    endtask

    task automatic test_reverse();
        int first, nvalid;
        int unsigned order [4];
        order = '{3, 2, 1, 0};
        do_reset();
        first = -1; nvalid = 0;
        for (int c = 0; c < 11; c++) begin
            if (c < 4) tick(1, make_msg(order[c]), 1);
            else tick(0, '0, 1);
            if (out_valid) begin
                nvalid++;
                if (first < 0) first = c;
            end
        end
        checks++;
        if (first != 4 || nvalid != 4) begin
            errors++;
            $display("FAIL reverse_timing: first=%0d count=%0d want first=4 count=4", first, nvalid);
        end
        checks++;
        if (got_q.size() != 4 || seq_of(got_q[0]) != 0 || seq_of(got_q[1]) != 1 ||
            seq_of(got_q[2]) != 2 || seq_of(got_q[3]) != 3) begin
            errors++; $display("FAIL reverse_order: got %0d outputs, want seq 0,1,2,3", got_q.size());
        end
        checks++;
        if (occupancy !== '0) begin
            errors++; $display("FAIL reverse_occ: got %0d want 0", occupancy);
        end
    endtask

    task automatic test_drops();
        logic [MSG_W-1:0] first12;
        do_reset();
        for (int c = 0; c < 10; c++) tick(1, make_msg(c), 1);
        tick(0, '0, 1);
        tick(0, '0, 1);
        checks++;
        if (expected_seq !== SEQ_W'(10)) begin
            errors++; $display("FAIL drops_preset: exp=%0d want 10", expected_seq);
        end
        got_q.delete();
        tick(1, make_msg(5), 1);
        checks++;
        if ({drop_stale, drop_window, drop_dup} !== 3'b100) begin
            errors++; $display("FAIL drop_stale: drops=%b want 100", {drop_stale, drop_window, drop_dup});
        end
        tick(0, '0, 1);
        checks++;
        if ({drop_stale, drop_window, drop_dup} !== 3'b000) begin
            errors++; $display("FAIL drop_pulse: drops=%b want 000", {drop_stale, drop_window, drop_dup});
        end
        tick(1, make_msg(74), 1);
        checks++;
        if ({drop_stale, drop_window, drop_dup} !== 3'b010) begin
            errors++; $display("FAIL drop_window: drops=%b want 010", {drop_stale, drop_window, drop_dup});
        end
        first12 = make_msg(12);
        tick(1, first12, 1);
        checks++;
        if ({drop_stale, drop_window, drop_dup} !== 3'b000 || occupancy !== OCC_W'(1)) begin
            errors++;
            $display("FAIL drop_store12: drops=%b occ=%0d want 000 occ=1",
                     {drop_stale, drop_window, drop_dup}, occupancy);
        end
        tick(1, make_msg(12), 1);
        checks++;
        if ({drop_stale, drop_window, drop_dup} !== 3'b001 || occupancy !== OCC_W'(1)) begin
            errors++;
            $display("FAIL drop_dup: drops=%b occ=%0d want 001 occ=1",
                     {drop_stale, drop_window, drop_dup}, occupancy);
        end
        tick(1, make_msg(10), 1);
        tick(1, make_msg(11), 1);
        for (int c = 0; c < 5; c++) tick(0, '0, 1);
        checks++;
        if (got_q.size() != 3 || seq_of(got_q[0]) != 10 || seq_of(got_q[1]) != 11 ||
            got_q[2] !== first12) begin
            errors++;
            $display("FAIL drop_keep_first: got %0d outputs, want 10,11 and first seq-12 payload",
                     got_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [MSG_W-1:0] m0, m1;
        do_reset();
        m0 = make_msg(0);
        m1 = make_msg(1);
        tick(1, m0, 0);
        tick(1, m1, 0);
        for (int c = 0; c < 5; c++) begin
            tick(0, '0, 0);
            checks++;
            if (out_valid !== 1'b1 || out_msg !== m0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b seq=%0d want valid=1 seq=0", c, out_valid,
                         seq_of(out_msg));
            end
        end
        for (int c = 0; c < 3; c++) tick(0, '0, 1);
        checks++;
        if (got_q.size() != 2 || got_q[0] !== m0 || got_q[1] !== m1) begin
            errors++; $display("FAIL bp_release: got %0d outputs want seq 0 then 1", got_q.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < SEQ_MOD - 2; c++) tick(1, make_msg(c), 1);
        tick(0, '0, 1);
        tick(0, '0, 1);
        checks++;
        if (expected_seq !== SEQ_W'(SEQ_MOD - 2)) begin
            errors++; $display("FAIL wrap_preset: exp=%0d want %0d", expected_seq, SEQ_MOD - 2);
        end
        got_q.delete();
        tick(1, make_msg(SEQ_MOD - 2), 1);
        tick(1, make_msg(SEQ_MOD - 1), 1);
        tick(1, make_msg(0), 1);
        for (int c = 0; c < 5; c++) tick(0, '0, 1);
        checks++;
        if (got_q.size() != 3 || seq_of(got_q[0]) != SEQ_MOD - 2 ||
            seq_of(got_q[1]) != SEQ_MOD - 1 || seq_of(got_q[2]) != 0) begin
            errors++; $display("FAIL wrap_order: got %0d outputs want %0d,%0d,0", got_q.size(),
                               SEQ_MOD - 2, SEQ_MOD - 1);
        end
        checks++;
        if (expected_seq !== SEQ_W'(1) || occupancy !== '0) begin
            errors++; $display("FAIL wrap_end: exp=%0d occ=%0d want exp=1 occ=0", expected_seq, occupancy);
        end
    endtask

    task automatic test_random();
        int unsigned r, s;
        bit v, rdy;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 99);
            if (r < 5) s = (m_exp + SEQ_MOD - 1 - $urandom_range(0, 20)) % SEQ_MOD;
            else if (r < 10) s = (m_exp + DEPTH + $urandom_range(0, 10)) % SEQ_MOD;
            else s = (m_exp + $urandom_range(0, 15)) % SEQ_MOD;
            v = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            tick(v, make_msg(s), rdy);
            checks++;
            if ({out_valid, occupancy, expected_seq, drop_stale, drop_window, drop_dup, gap_skip} !==
                {m_out_valid, OCC_W'(m_buf.num()), SEQ_W'(m_exp), m_stale, m_window, m_dup, m_skip})
            begin
                errors++;
                $display("FAIL rand_state[%0d]: ov=%b occ=%0d exp=%0d drops=%b%b%b skip=%b, want ov=%b occ=%0d exp=%0d drops=%b%b%b skip=%b",
                         c, out_valid, occupancy, expected_seq, drop_stale, drop_window, drop_dup,
                         gap_skip, m_out_valid, m_buf.num(), m_exp, m_stale, m_window, m_dup, m_skip);
            end
            if (m_out_valid) begin
                checks++;
                if (out_msg !== m_out_msg) begin
                    errors++;
                    $display("FAIL rand_msg[%0d]: seq %0d want seq %0d", c, seq_of(out_msg),
                             seq_of(m_out_msg));
                end
            end
        end
    endtask

    task automatic test_gap();
        int first_skip;
        int seen;
        do_reset();
        tick(1, make_msg(1), 1);
`ifdef SEQ_REORDER_GAP_SKIP_EN
        first_skip = -1;
        for (int c = 1; c <= GAP_TIMEOUT + 4; c++) begin
            tick(0, '0, 1);
            if (gap_skip && first_skip < 0) first_skip = c;
            checks++;
            if (gap_skip !== m_skip) begin
                errors++; $display("FAIL gap_pulse[%0d]: got %b want %b", c, gap_skip, m_skip);
            end
        end
        checks++;
        if (first_skip != GAP_TIMEOUT) begin
            errors++; $display("FAIL gap_timing: skip at %0d want %0d", first_skip, GAP_TIMEOUT);
        end
        checks++;
        if (got_q.size() != 1 || seq_of(got_q[0]) != 1 || expected_seq !== SEQ_W'(2)) begin
            errors++;
            $display("FAIL gap_release: outputs=%0d exp=%0d want seq 1 released exp=2",
                     got_q.size(), expected_seq);
        end
`else
        first_skip = 0;
        seen = 0;
        for (int c = 0; c < 1000; c++) begin
            tick(0, '0, 1);
            if (out_valid || gap_skip) seen++;
        end
        checks++;
        if (seen != first_skip) begin
            errors++; $display("FAIL gap_stall: %0d cycles with output or skip want 0", seen);
        end
        checks++;
        if (occupancy !== OCC_W'(1) || expected_seq !== '0) begin
            errors++; $display("FAIL gap_stall_state: occ=%0d exp=%0d want occ=1 exp=0",
                               occupancy, expected_seq);
        end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_in_order();
        test_reverse();
        test_drops();
        test_backpressure();
        test_wrap();
        test_random();
        test_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
